// File: rtl/axis_dwc_pkg.sv
// Shared types and helpers for the parametrised AXI-Stream width downsizer.
// The optional trailing-null-word trimming is enabled by defining AXIS_DWC_NULL_SKIP_EN.
package axis_dwc_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Index registers need at least one bit, even when RATIO is 1.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_dwidth_downsizer_n_if.sv
// AXI-Stream bundle used on both sides of the downsizer; width set per instance.
interface axis_dwidth_downsizer_n_if
    import axis_dwc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    localparam int KEEP_WIDTH = DATA_WIDTH / BYTE_WIDTH;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axis_dwc_last_word.sv
// Priority encoder: index of the highest output word whose tkeep slice is non-zero.
// An all-zero tkeep maps to index 0 so a packet boundary is never lost.
module axis_dwc_last_word
    import axis_dwc_pkg::*;
#(
    parameter int M_KEEP_WIDTH = 4,
    parameter int RATIO        = 2,
    localparam int IDX_W       = idx_width(RATIO)
) (
    input  logic [M_KEEP_WIDTH*RATIO-1:0] keep,
    output logic [IDX_W-1:0]              last_idx
);

    // NOTE: defaulting every always_comb output before the loop keeps it
    // fully assigned on every path, so no latch is inferred.
    always_comb begin
        last_idx = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (|keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH]) last_idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/axis_dwidth_downsizer_n.sv
// Splits each RATIO*M_DATA_WIDTH input beat into RATIO output words, LSB word first,
// at full throughput. Define AXIS_DWC_NULL_SKIP_EN to drop trailing null words on tlast beats.
module axis_dwidth_downsizer_n
    import axis_dwc_pkg::*;
#(
    parameter int M_DATA_WIDTH = 32,
    parameter int RATIO        = 2
) (
    input logic                   aclk,
    input logic                   areset,
    axis_dwidth_downsizer_n_if.slave  s_axis,
    axis_dwidth_downsizer_n_if.master m_axis
);

    localparam int S_DATA_WIDTH = M_DATA_WIDTH * RATIO;
    localparam int M_KEEP_WIDTH = M_DATA_WIDTH / BYTE_WIDTH;
    localparam int S_KEEP_WIDTH = M_KEEP_WIDTH * RATIO;
    localparam int IDX_W        = idx_width(RATIO);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(RATIO - 1);

    state_t                  state;
    logic [S_DATA_WIDTH-1:0] buf_data;
    logic [S_KEEP_WIDTH-1:0] buf_keep;
    logic                    buf_last;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        last_idx;
    logic [IDX_W-1:0]        in_last_idx;

    logic                    loaded;
    logic                    at_last;
    logic                    s_ready;
    logic                    in_hs;
    logic                    out_hs;
    logic [M_DATA_WIDTH-1:0] cur_word;
    logic [M_KEEP_WIDTH-1:0] cur_keep;

`ifdef AXIS_DWC_NULL_SKIP_EN
    logic [IDX_W-1:0] keep_last_idx;

    axis_dwc_last_word #(
        .M_KEEP_WIDTH (M_KEEP_WIDTH),
        .RATIO        (RATIO)
    ) u_last_word (
        .keep     (s_axis.tkeep),
        .last_idx (keep_last_idx)
    );

    // Only packet-ending beats are trimmed; mid-packet beats always emit every word.
    assign in_last_idx = s_axis.tlast ? keep_last_idx : FULL_IDX;
`else
    assign in_last_idx = FULL_IDX;
`endif

    assign loaded  = (state == DRAIN);
    assign at_last = (idx == last_idx);

    // Accepting while the final word leaves is what removes the bubble between beats.
    assign s_ready = !areset && (!loaded || (m_axis.tready && at_last));
    assign in_hs   = s_axis.tvalid && s_ready;
    assign out_hs  = m_axis.tvalid && m_axis.tready;

    always_comb begin
        cur_word = '0;
        cur_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_word = buf_data[k*M_DATA_WIDTH +: M_DATA_WIDTH];
                cur_keep = buf_keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
            end
        end
    end

    assign s_axis.tready = s_ready;

    // Outputs are forced quiet during the reset cycle itself, before the registers clear.
    assign m_axis.tvalid = loaded && !areset;
    assign m_axis.tdata  = areset ? '0 : cur_word;
    assign m_axis.tkeep  = areset ? '0 : cur_keep;
    assign m_axis.tlast  = loaded && !areset && buf_last && at_last;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, matching the hardware it describes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= EMPTY;
            idx      <= '0;
            last_idx <= '0;
            // NOTE: the data buffer is cleared on reset so stale words can
            // never reach the output; plain datapath storage usually is not.
            buf_data <= '0;
            buf_keep <= '0;
            buf_last <= 1'b0;
        end else if (in_hs) begin
            state    <= DRAIN;
            idx      <= '0;
            last_idx <= in_last_idx;
            buf_data <= s_axis.tdata;
            buf_keep <= s_axis.tkeep;
            buf_last <= s_axis.tlast;
        end else if (out_hs) begin
            if (at_last) state <= EMPTY;
            else         idx   <= idx + 1'b1;
        end
    end

endmodule

// File: doc/axis_dwidth_downsizer_n.md
Name: axis_dwidth_downsizer_n

Overview:
Parametrised successor to the fixed 64->32 AXI-Stream downsizer. It splits each S_DATA_WIDTH input beat into RATIO output beats of M_DATA_WIDTH, least-significant word first. It adds tkeep handling and tlast-aware beat trimming, and sustains full throughput with no bubble between input beats. It sits between wide datapath stages and narrow consumers (DMA, serialisers).

Parameters:
M_DATA_WIDTH, 32, output word width in bits; multiple of 8, >= 8.
RATIO, 2, output beats per input beat; >= 1; S_DATA_WIDTH = M_DATA_WIDTH*RATIO (localparam).
M_KEEP_WIDTH (localparam), M_DATA_WIDTH/8; S_KEEP_WIDTH = M_KEEP_WIDTH*RATIO.

Ports:
aclk  in  1  clock, all logic rising-edge.
areset  in  1  synchronous, active-high reset.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  input beat accepted when high with tvalid.
s_axis_tdata  in  S_DATA_WIDTH  input data; word k = bits [k*M_DATA_WIDTH +: M_DATA_WIDTH].
s_axis_tkeep  in  S_KEEP_WIDTH  byte qualifiers.
s_axis_tlast  in  1  packet end.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  M_DATA_WIDTH  current word.
m_axis_tkeep  out  M_KEEP_WIDTH  tkeep slice of current word.
m_axis_tlast  out  1  high only on final emitted word of a tlast input beat.

Behaviour:
- Storage: buf_data, buf_keep, buf_last, loaded flag, idx (clog2(RATIO) bits, min 1), last_idx.
- States: EMPTY (loaded=0) and DRAIN (loaded=1, emitting word idx).
- Reset (areset=1 at clock edge): loaded=0, idx=0, buf_* = 0. Output values while areset high and the cycle after: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0. s_axis_tready is forced 0 while areset is high.
- Reset mid-packet discards the buffered beat; no partial words are emitted afterwards.
- m_axis_tvalid = loaded. m_axis_tdata/tkeep = buf slice idx. m_axis_tlast = buf_last && (idx==last_idx).
- s_axis_tready = !areset && (!loaded || (m_axis_tready && idx==last_idx)). Combinational from registers plus m_axis_tready.
- Input handshake: load buf_*, idx=0, last_idx computed from the incoming beat, loaded=1. Latency is 1 cycle from input accept to first output word valid.
- Output handshake with idx<last_idx: idx++.
- Output handshake with idx==last_idx: loaded=0, unless a new input handshake occurs in the same cycle, in which case reload. This gives back-to-back beats with no gap, RATIO output beats per input beat.
- m_axis_tready low: all outputs hold stable (AXIS rule); s_axis_tready stays 0 while loaded.
- s_axis_tvalid dropping mid-drain has no effect on buffered words.
- last_idx = RATIO-1 unless the optional feature applies.
- RATIO=1: degenerates to a one-deep register slice with the same handshake rules (half throughput is not allowed; the same-cycle reload covers it).

Optional Feature:
Macro AXIS_DWC_NULL_SKIP_EN.
- Defined: on a tlast input beat, last_idx = highest word index whose tkeep slice is non-zero. Trailing all-zero-keep words are not emitted. If tkeep is entirely zero, last_idx=0 and one word with tkeep=0 and tlast=1 is emitted, preserving the packet boundary.
- Non-tlast beats always emit RATIO words.
- Undefined: last_idx is always RATIO-1 and tkeep is passed through unmodified.

Decomposition:
- Package axis_dwc_pkg: function for index width (clog2 with minimum 1); constants for keep-width derivation; typedef for the state enum {EMPTY, DRAIN}.
- One sub-module: axis_dwc_last_word, a combinational priority encoder from S_KEEP_WIDTH tkeep to the highest non-zero word index, parametrised by M_KEEP_WIDTH and RATIO. Instantiated only under AXIS_DWC_NULL_SKIP_EN.

Test Plan:
- RATIO=2, M=32, m_ready=1, stream tdata=0x00000001_00000064 then 0x00000002_00000074 (tkeep all 1, tvalid continuous) -> outputs 0x64, 0x1, 0x74, 0x2 on consecutive cycles, s_axis_tready toggling 1,0,1,0, no bubbles.
- RATIO=4, tlast=1 on beat 0x4444_3333_2222_1111 (M=16) -> four words 0x1111..0x4444; tlast only on 0x4444.
- m_axis_tready pattern 1,0,0,1 during drain -> data/tkeep/tlast stable while stalled, no word lost or duplicated, scoreboard matches.
- With AXIS_DWC_NULL_SKIP_EN, RATIO=4, M=32, tlast beat tkeep=0x00FF -> exactly 2 words emitted, second has tlast=1. With tkeep=0x0000 -> 1 word, tkeep=0, tlast=1. Without the macro -> 4 words, tlast on the 4th.
- Assert areset for one cycle after the second word of a RATIO=4 beat -> m_axis_tvalid=0 the following cycle, and the next accepted beat starts at word 0.
- Random valid/ready, RATIO in {1,2,3,8} -> output stream equals the LSB-first concatenation of inputs; tlast count equals input tlast count.
